// File: rtl/bf_controller.sv
`default_nettype none
// ============================================================================
// Module   : bf_controller
// Brief    : Brainfuck instruction sequencer. Fetches from a registered ROM,
//            resolves [ ] flow with a return stack and skip-depth counter,
//            and hands data ops to the data path through valid/ready.
//            Optional macro BF_STACK_CHECK_EN adds stack/depth bound checks.
// Revision : 1.0 - initial release
// ============================================================================
module bf_controller #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              cell_zero,
    output logic              op_valid,
    output logic [2:0]        op_code,
    input  logic              op_ready,
    output logic              halted,
    output logic              error
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [ADDR_W-1:0] c_PC_LAST  = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_WRAP     = CNT_W'(STACK_DEPTH - 1);
    localparam logic [7:0]        c_CH_NUL   = 8'h00;
    localparam logic [7:0]        c_CH_OPEN  = 8'h5B;
    localparam logic [7:0]        c_CH_CLOSE = 8'h5D;

    typedef enum logic [2:0] {
        S_FETCH       = 3'd0,
        S_DECODE      = 3'd1,
        S_ISSUE       = 3'd2,
        S_SKIP_FETCH  = 3'd3,
        S_SKIP_DECODE = 3'd4,
        S_HALT        = 3'd5,
        S_ERROR       = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    sp_q, sp_d;
    logic [CNT_W-1:0]    depth_q, depth_d;
    logic [2:0]          op_code_q, op_code_d;
    logic                halted_q, halted_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

    logic                w_is_op;
    logic [2:0]          w_dec_code;
    logic                w_pc_last;
    logic [ADDR_W-1:0]   w_pc_inc;
    state_t              w_adv_state;
    logic [ADDR_W-1:0]   w_adv_pc;
    logic                w_push_en;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_top_idx;
    logic                w_push_ovf;
    logic                w_stack_empty;
    logic                w_depth_ovf;
    logic [CNT_W-1:0]    w_sp_inc;
    logic [CNT_W-1:0]    w_sp_dec;
    logic [CNT_W-1:0]    w_depth_inc;
    logic [CNT_W-1:0]    w_depth_dec;

    assign rom_addr = pc_q;
    assign op_valid = (state_q == S_ISSUE);
    assign op_code  = op_code_q;
    assign halted   = halted_q;
    assign error    = error_q;

    // Stepping past the last ROM address ends the program instead of wrapping.
    assign w_pc_last   = (pc_q == c_PC_LAST);
    assign w_pc_inc    = pc_q + ADDR_W'(1);
    assign w_adv_state = w_pc_last ? S_HALT : S_FETCH;
    assign w_adv_pc    = w_pc_last ? pc_q : w_pc_inc;

    assign w_push_idx  = IDX_W'(sp_q);
    assign w_top_idx   = (sp_q == '0) ? IDX_W'(c_WRAP) : IDX_W'(sp_q - CNT_W'(1));

`ifdef BF_STACK_CHECK_EN
    localparam logic [CNT_W-1:0] c_DEPTH_MAX = CNT_W'(STACK_DEPTH);

    assign w_push_ovf    = (sp_q == c_DEPTH_MAX);
    assign w_stack_empty = (sp_q == '0);
    assign w_depth_ovf   = (depth_q == c_DEPTH_MAX);
    assign w_sp_inc      = sp_q + CNT_W'(1);
    assign w_sp_dec      = sp_q - CNT_W'(1);
    assign w_depth_inc   = depth_q + CNT_W'(1);
    assign w_depth_dec   = depth_q - CNT_W'(1);
`else
    assign w_push_ovf    = 1'b0;
    assign w_stack_empty = 1'b0;
    assign w_depth_ovf   = 1'b0;
    assign w_sp_inc      = (sp_q == c_WRAP) ? '0 : sp_q + CNT_W'(1);
    assign w_sp_dec      = (sp_q == '0) ? c_WRAP : sp_q - CNT_W'(1);
    assign w_depth_inc   = (depth_q == c_WRAP) ? '0 : depth_q + CNT_W'(1);
    assign w_depth_dec   = (depth_q == '0) ? c_WRAP : depth_q - CNT_W'(1);
`endif

    always_comb begin
        w_is_op    = 1'b1;
        w_dec_code = 3'd0;
        case (rom_data)
            8'h2B:   w_dec_code = 3'd0;
            8'h2D:   w_dec_code = 3'd1;
            8'h3E:   w_dec_code = 3'd2;
            8'h3C:   w_dec_code = 3'd3;
            8'h2E:   w_dec_code = 3'd4;
            8'h2C:   w_dec_code = 3'd5;
            default: w_is_op    = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        op_code_d = op_code_q;
        w_push_en = 1'b0;

        case (state_q)
            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                if (rom_data == c_CH_NUL) begin
                    state_d = S_HALT;
                end else if (w_is_op) begin
                    op_code_d = w_dec_code;
                    state_d   = S_ISSUE;
                end else if (rom_data == c_CH_OPEN) begin
                    if (cell_zero) begin
                        if (w_pc_last) begin
                            state_d = S_ERROR;
                        end else begin
                            depth_d = CNT_W'(1);
                            pc_d    = w_pc_inc;
                            state_d = S_SKIP_FETCH;
                        end
                    end else if (w_push_ovf) begin
                        state_d = S_ERROR;
                    end else begin
                        w_push_en = 1'b1;
                        sp_d      = w_sp_inc;
                        pc_d      = w_adv_pc;
                        state_d   = w_adv_state;
                    end
                end else if (rom_data == c_CH_CLOSE) begin
                    // Loop-back peeks the stack; only the exit path pops it.
                    if (w_stack_empty) begin
                        state_d = S_ERROR;
                    end else if (!cell_zero) begin
                        pc_d    = stack_q[w_top_idx];
                        state_d = S_FETCH;
                    end else begin
                        sp_d    = w_sp_dec;
                        pc_d    = w_adv_pc;
                        state_d = w_adv_state;
                    end
                end else begin
                    pc_d    = w_adv_pc;
                    state_d = w_adv_state;
                end
            end

            S_ISSUE: begin
                if (op_ready) begin
                    pc_d    = w_adv_pc;
                    state_d = w_adv_state;
                end
            end

            S_SKIP_FETCH: state_d = S_SKIP_DECODE;

            S_SKIP_DECODE: begin
                if (rom_data == c_CH_NUL) begin
                    state_d = S_ERROR;
                end else if (rom_data == c_CH_OPEN) begin
                    if (w_depth_ovf || w_pc_last) begin
                        state_d = S_ERROR;
                    end else begin
                        depth_d = w_depth_inc;
                        pc_d    = w_pc_inc;
                        state_d = S_SKIP_FETCH;
                    end
                end else if ((rom_data == c_CH_CLOSE) && (w_depth_dec == '0)) begin
                    depth_d = '0;
                    pc_d    = w_adv_pc;
                    state_d = w_adv_state;
                end else if (w_pc_last) begin
                    state_d = S_ERROR;
                end else begin
                    if (rom_data == c_CH_CLOSE) begin
                        depth_d = w_depth_dec;
                    end
                    pc_d    = w_pc_inc;
                    state_d = S_SKIP_FETCH;
                end
            end

            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            sp_q      <= '0;
            depth_q   <= '0;
            op_code_q <= 3'd0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            depth_q   <= depth_d;
            op_code_q <= op_code_d;
            halted_q  <= halted_d;
            error_q   <= error_d;
            if (w_push_en) begin
                stack_q[w_push_idx] <= w_pc_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_controller
// Brief    : Self-checking bench for bf_controller: a brainfuck interpreter
//            model predicts per-cycle ROM address, op offers and end state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_controller;

    localparam int ADDR_W      = 4;
    localparam int STACK_DEPTH = 8;
    localparam int ROM_SIZE    = 1 << ADDR_W;
    localparam int LAST        = ROM_SIZE - 1;
    localparam int MAXC        = 8192;
`ifdef BF_STACK_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              cell_zero;
    logic              op_valid;
    logic [2:0]        op_code;
    logic              op_ready;
    logic              halted;
    logic              error;

    bf_controller #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .cell_zero(cell_zero), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [ROM_SIZE];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Data path: 8-bit tape updated when an op is accepted.
    logic [7:0] tape [256];
    logic [7:0] tptr;
    assign cell_zero = (tape[tptr] == 8'd0);

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] e_addr  [MAXC];
    bit                e_valid [MAXC];
    logic [2:0]        e_code  [MAXC];
    bit                e_halt  [MAXC];
    bit                e_err   [MAXC];
    int                m_term, m_ncyc, m_nops;

    int                obs_ops;
    logic [2:0]        obs_codes [$];
    int                obs_opaddr [$];
    int                obs_addrs [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int op_index(input logic [7:0] b);
        case (b)
            8'h2B:   return 0;
            8'h2D:   return 1;
            8'h3E:   return 2;
            8'h3C:   return 3;
            8'h2E:   return 4;
            8'h2C:   return 5;
            default: return -1;
        endcase
    endfunction

    task automatic load_rom(input string s);
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic model_fill(input int t, input int k, input int pc);
        for (int i = 0; i < k; i++) e_addr[t + i] = ADDR_W'(pc);
    endtask

    // Interpreter: every byte costs 2 cycles, a data op 3 (op_ready held high).
    task automatic run_model(input logic [7:0] init_cell);
        int t, pc, sp, depth, ptr, code;
        int stk [STACK_DEPTH];
        logic [7:0] mt [256];
        logic [7:0] b;
        bit done, err;
        for (int i = 0; i < MAXC; i++) begin
            e_addr[i] = '0; e_valid[i] = 0; e_code[i] = 3'd0; e_halt[i] = 0; e_err[i] = 0;
        end
        for (int i = 0; i < 256; i++) mt[i] = 8'd0;
        for (int i = 0; i < STACK_DEPTH; i++) stk[i] = 0;
        mt[0] = init_cell;
        t = 0; pc = 0; sp = 0; ptr = 0; done = 0; err = 0; m_nops = 0;
        while (!done && t < MAXC - 16) begin
            b = rom[pc];
            code = op_index(b);
            if (b == 8'h00) begin
                model_fill(t, 2, pc); t += 2; done = 1;
            end else if (code >= 0) begin
                model_fill(t, 3, pc);
                e_valid[t + 2] = 1; e_code[t + 2] = 3'(code); m_nops++;
                case (code)
                    0: mt[ptr] = mt[ptr] + 8'd1;
                    1: mt[ptr] = mt[ptr] - 8'd1;
                    2: ptr = (ptr + 1) % 256;
                    3: ptr = (ptr + 255) % 256;
                    default: ;
                endcase
                t += 3;
                if (pc == LAST) done = 1; else pc++;
            end else begin
                model_fill(t, 2, pc); t += 2;
                if (b == 8'h5B && mt[ptr] == 0) begin
                    if (pc == LAST) begin done = 1; err = 1; end
                    else begin
                        depth = 1; pc++;
                        while (!done) begin
                            model_fill(t, 2, pc); t += 2; b = rom[pc];
                            if (b == 8'h00) begin done = 1; err = 1; end
                            else if (b == 8'h5B) begin
                                depth++;
                                if ((CHECK && depth > STACK_DEPTH) || pc == LAST) begin done = 1; err = 1; end
                                if (!CHECK) depth = depth % STACK_DEPTH;
                            end else if (b == 8'h5D) begin
                                depth = CHECK ? depth - 1 : (depth + STACK_DEPTH - 1) % STACK_DEPTH;
                                if (depth == 0) begin
                                    if (pc == LAST) done = 1; else pc++;
                                    break;
                                end else if (pc == LAST) begin done = 1; err = 1; end
                            end else if (pc == LAST) begin done = 1; err = 1; end
                            if (!done) pc++;
                        end
                    end
                end else if (b == 8'h5B) begin
                    if (CHECK && sp == STACK_DEPTH) begin done = 1; err = 1; end
                    else begin
                        stk[sp % STACK_DEPTH] = pc + 1;
                        sp = CHECK ? sp + 1 : (sp + 1) % STACK_DEPTH;
                        if (pc == LAST) done = 1; else pc++;
                    end
                end else if (b == 8'h5D) begin
                    if (CHECK && sp == 0) begin done = 1; err = 1; end
                    else if (mt[ptr] != 0) pc = stk[(sp + STACK_DEPTH - 1) % STACK_DEPTH];
                    else begin
                        sp = CHECK ? sp - 1 : (sp + STACK_DEPTH - 1) % STACK_DEPTH;
                        if (pc == LAST) done = 1; else pc++;
                    end
                end else begin
                    if (pc == LAST) done = 1; else pc++;
                end
            end
        end
        m_term = t;
        for (int i = t; i < t + 4; i++) begin
            e_addr[i] = ADDR_W'(pc); e_halt[i] = !err; e_err[i] = err;
        end
        m_ncyc = t + 4;
    endtask

    task automatic do_reset(input logic [7:0] init_cell, input logic rdy);
        reset = 1'b1;
        op_ready = rdy;
        for (int i = 0; i < 256; i++) tape[i] = 8'd0;
        tape[0] = init_cell;
        tptr = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_dut(input string name, input logic [7:0] init_cell);
        int fails_here;
        logic [9:0] act, exp;
        fails_here = 0;
        obs_ops = 0;
        obs_codes.delete(); obs_opaddr.delete(); obs_addrs.delete();
        do_reset(init_cell, 1'b1);
        for (int c = 0; c < m_ncyc && fails_here < 10; c++) begin
            act = {rom_addr, op_valid, (op_valid ? op_code : 3'd0), halted, error};
            exp = {e_addr[c], e_valid[c], e_code[c], e_halt[c], e_err[c]};
            n_checks++;
            if (act !== exp) begin
                n_errors++; fails_here++;
                $display("FAIL %s cycle %0d: got addr=%0d valid=%0b code=%0d halted=%0b error=%0b expected addr=%0d valid=%0b code=%0d halted=%0b error=%0b",
                         name, c, act[9:6], act[5], act[4:2], act[1], act[0],
                         exp[9:6], exp[5], exp[4:2], exp[1], exp[0]);
            end
            if (obs_addrs.size() == 0 || obs_addrs[$] != int'(rom_addr)) obs_addrs.push_back(int'(rom_addr));
            if (op_valid && op_ready) begin
                obs_ops++;
                obs_codes.push_back(op_code);
                obs_opaddr.push_back(int'(rom_addr));
                case (op_code)
                    3'd0: tape[tptr] = tape[tptr] + 8'd1;
                    3'd1: tape[tptr] = tape[tptr] - 8'd1;
                    3'd2: tptr = tptr + 8'd1;
                    3'd3: tptr = tptr - 8'd1;
                    default: ;
                endcase
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_term;
        reset = 1'b1;
        op_ready = 1'b0;
        for (int i = 0; i < 256; i++) tape[i] = 8'd0;
        tptr = 8'd0;
        load_rom("");
        #1;
        check("reset_addr", int'(rom_addr), 0);
        check("reset_valid", int'(op_valid), 0);
        check("reset_code", int'(op_code), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_error", int'(error), 0);

        // Counting loops up through 255 and back down; halts at 0x00 (addr 0xB).
        load_rom("+[.+]>-[.-]");
        run_model(8'd0);
        check("t1_model_term", m_term, 4095);
        check("t1_model_ops", m_nops, 1023);
        run_dut("t1", 8'd0);
        check("t1_ops", obs_ops, 1023);
        check("t1_first_code", int'(obs_codes[0]), 0);
        check("t1_second_code", int'(obs_codes[1]), 4);

        // Skip over [+] with cell 0; PC visits 0..5.
        load_rom("[+]>.");
        run_model(8'd0);
        check("t2_model_term", m_term, 14);
        run_dut("t2", 8'd0);
        check("t2_ops", obs_ops, 2);
        check("t2_code0", int'(obs_codes[0]), 2);
        check("t2_code1", int'(obs_codes[1]), 4);
        check("t2_addr_seq_len", obs_addrs.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_addr_seq", obs_addrs[i], i);

        // Nested skip; only the trailing + at addr 6 issues.
        load_rom("[[+]+]+");
        run_model(8'd0);
        check("t3_model_term", m_term, 17);
        run_dut("t3", 8'd0);
        check("t3_ops", obs_ops, 1);
        check("t3_op_addr", obs_opaddr[0], 6);

        // Unterminated skip hits 0x00.
        load_rom("[+");
        run_model(8'd0);
        check("t4_model_term", m_term, 6);
        run_dut("t4", 8'd0);
        check("t4_error", int'(error), 1);

        // Op at the last address ends the program without wrapping.
        load_rom("xxxxxxxxxxxxxxx+");
        run_model(8'd0);
        check("t5_model_term", m_term, 33);
        run_dut("t5", 8'd0);
        check("t5_op_addr", obs_opaddr[0], 15);
        check("t5_halted", int'(halted), 1);

        // Nine nested pushes: overflow with checks, plain halt without.
        load_rom("[[[[[[[[[");
        run_model(8'd1);
        exp_term = CHECK ? 18 : 20;
        check("t6_model_term", m_term, exp_term);
        run_dut("t6", 8'd1);
        check("t6_error", int'(error), int'(CHECK));

`ifdef BF_STACK_CHECK_EN
        load_rom("]");
        run_model(8'd1);
        check("t7_model_term", m_term, 2);
        run_dut("t7", 8'd1);
        check("t7_error", int'(error), 1);
`endif

        // Back-pressure: offer must hold steady with the PC parked.
        load_rom("-");
        do_reset(8'd0, 1'b0);
        repeat (2) begin @(negedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(op_valid), 1);
            check("stall_code", int'(op_code), 1);
            check("stall_pc", int'(rom_addr), 0);
            @(negedge clk); #1;
        end
        op_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_release_valid", int'(op_valid), 0);
        check("stall_release_pc", int'(rom_addr), 1);
        for (int k = 0; k < 10 && !halted; k++) begin @(negedge clk); #1; end
        check("stall_halted", int'(halted), 1);

        // Asynchronous reset during ISSUE, then a clean restart.
        load_rom("x+");
        do_reset(8'd0, 1'b0);
        repeat (4) begin @(negedge clk); #1; end
        check("rst_pre_valid", int'(op_valid), 1);
        check("rst_pre_pc", int'(rom_addr), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_valid", int'(op_valid), 0);
        check("rst_pc", int'(rom_addr), 0);
        check("rst_code", int'(op_code), 0);
        run_model(8'd0);
        run_dut("rst_restart", 8'd0);
        check("rst_restart_ops", obs_ops, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
